// File: rtl/rtc_alarm_sched.sv
// rtc_alarm_sched: programmable hh:mm alarm slots watched against the RTC.
// A minute change (tick) queues every enabled matching slot; the lowest
// queued slot rings until acknowledged (dismiss or snooze) or until it has
// been ignored for RING_MIN minutes, which sets its sticky missed flag.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rtc_hh, rtc_mm      current RTC time
//   cfg_wr/idx/hh/mm/en slot write port; cfg_err pulses on a rejected write
//   alarm_req/idx       ring request and ringing slot
//   alarm_ack, snooze   ring handshake (snooze=1 re-rings after SNOOZE_MIN)
//   missed              per-slot sticky timeout flags
module rtc_alarm_sched #(
  parameter int unsigned NUM_ALARMS = 4,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_MIN   = 2,
  localparam int unsigned IDXW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            rtc_hh,
  input  logic [5:0]            rtc_mm,
  input  logic                  cfg_wr,
  input  logic [IDXW-1:0]       cfg_idx,
  input  logic [4:0]            cfg_hh,
  input  logic [5:0]            cfg_mm,
  input  logic                  cfg_en,
  output logic                  cfg_err,
  output logic                  alarm_req,
  output logic [IDXW-1:0]       alarm_idx,
  input  logic                  alarm_ack,
  input  logic                  snooze,
  output logic [NUM_ALARMS-1:0] missed
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RING = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [4:0]            slot_hh_q [NUM_ALARMS];
  logic [4:0]            slot_hh_d [NUM_ALARMS];
  logic [5:0]            slot_mm_q [NUM_ALARMS];
  logic [5:0]            slot_mm_d [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] slot_en_q, slot_en_d;
  logic [NUM_ALARMS-1:0] pending_q, pending_d;
  logic [NUM_ALARMS-1:0] missed_q, missed_d;
  logic [5:0]            prev_mm_q, prev_mm_d;
  logic                  prev_vld_q, prev_vld_d;
  logic                  snz_act_q, snz_act_d;
  logic [IDXW-1:0]       snz_idx_q, snz_idx_d;
  logic [5:0]            snz_cnt_q, snz_cnt_d;
  logic [IDXW-1:0]       ring_idx_q, ring_idx_d;
  logic [5:0]            ring_cnt_q, ring_cnt_d;
  logic                  alarm_req_q, alarm_req_d;
  logic                  cfg_err_q, cfg_err_d;

  logic                  tick;
  logic                  wr_ok;
  logic                  kill;
  logic                  snz_fire;
  logic                  sel_vld;
  logic [IDXW-1:0]       sel_idx;

  // Next-state logic; later assignments override earlier ones, so the
  // order below encodes the in-cycle priority (config write wins last).
  always_comb begin
    state_d     = state_q;
    slot_hh_d   = slot_hh_q;
    slot_mm_d   = slot_mm_q;
    slot_en_d   = slot_en_q;
    pending_d   = pending_q;
    missed_d    = missed_q;
    prev_mm_d   = rtc_mm;
    prev_vld_d  = 1'b1;
    snz_act_d   = snz_act_q;
    snz_idx_d   = snz_idx_q;
    snz_cnt_d   = snz_cnt_q;
    ring_idx_d  = ring_idx_q;
    ring_cnt_d  = ring_cnt_q;
    snz_fire    = 1'b0;
    sel_vld     = 1'b0;
    sel_idx     = '0;

    tick      = prev_vld_q && (rtc_mm != prev_mm_q);
    wr_ok     = cfg_wr && (cfg_hh <= 5'd23) && (cfg_mm <= 6'd59);
    cfg_err_d = cfg_wr && !wr_ok;
    kill      = wr_ok && !cfg_en && (cfg_idx == ring_idx_q);

    // Lowest-index pending slot (scan high to low so the lowest wins)
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_vld = 1'b1;
        sel_idx = IDXW'(i);
      end
    end

    // Snooze countdown; expiry re-queues the snoozed slot
    if (tick && snz_act_q) begin
      snz_cnt_d = snz_cnt_q - 6'd1;
      if (snz_cnt_q <= 6'd1) begin
        snz_fire  = 1'b1;
        snz_act_d = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (sel_vld) begin
          state_d    = ST_RING;
          ring_idx_d = sel_idx;
          ring_cnt_d = 6'(RING_MIN);
          for (int i = 0; i < NUM_ALARMS; i++) begin
            if (sel_idx == IDXW'(i)) pending_d[i] = 1'b0;
          end
        end
      end
      ST_RING: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else if (alarm_ack) begin
          state_d = ST_IDLE;
          if (snooze) begin
            snz_act_d = 1'b1;
            snz_idx_d = ring_idx_q;
            snz_cnt_d = 6'(SNOOZE_MIN);
          end
        end else if (tick) begin
          if (ring_cnt_q <= 6'd1) begin
            state_d = ST_IDLE;
            for (int i = 0; i < NUM_ALARMS; i++) begin
              if (ring_idx_q == IDXW'(i)) missed_d[i] = 1'b1;
            end
          end else begin
            ring_cnt_d = ring_cnt_q - 6'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Queue matches (old slot contents) and snooze expiry; a set beats the
    // selection clear so a slot matching while being selected re-queues.
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (tick && slot_en_q[i] && (slot_hh_q[i] == rtc_hh) && (slot_mm_q[i] == rtc_mm))
        pending_d[i] = 1'b1;
      if (snz_fire && (snz_idx_q == IDXW'(i)))
        pending_d[i] = 1'b1;
    end

    // Accepted write: update slot, drop its queued/missed state
    if (wr_ok) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (cfg_idx == IDXW'(i)) begin
          slot_hh_d[i] = cfg_hh;
          slot_mm_d[i] = cfg_mm;
          slot_en_d[i] = cfg_en;
          pending_d[i] = 1'b0;
          missed_d[i]  = 1'b0;
        end
      end
      if (snz_act_d && (snz_idx_d == cfg_idx)) snz_act_d = 1'b0;
    end

    alarm_req_d = (state_d == ST_RING);
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        slot_hh_q[i] <= 5'd0;
        slot_mm_q[i] <= 6'd0;
      end
      slot_en_q   <= '0;
      pending_q   <= '0;
      missed_q    <= '0;
      prev_mm_q   <= 6'd0;
      prev_vld_q  <= 1'b0;
      snz_act_q   <= 1'b0;
      snz_idx_q   <= '0;
      snz_cnt_q   <= 6'd0;
      ring_idx_q  <= '0;
      ring_cnt_q  <= 6'd0;
      alarm_req_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_hh_q   <= slot_hh_d;
      slot_mm_q   <= slot_mm_d;
      slot_en_q   <= slot_en_d;
      pending_q   <= pending_d;
      missed_q    <= missed_d;
      prev_mm_q   <= prev_mm_d;
      prev_vld_q  <= prev_vld_d;
      snz_act_q   <= snz_act_d;
      snz_idx_q   <= snz_idx_d;
      snz_cnt_q   <= snz_cnt_d;
      ring_idx_q  <= ring_idx_d;
      ring_cnt_q  <= ring_cnt_d;
      alarm_req_q <= alarm_req_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign alarm_req = alarm_req_q;
  assign alarm_idx = ring_idx_q;
  assign missed    = missed_q;
  assign cfg_err   = cfg_err_q;

endmodule
